// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stall and forwarding controller for the D stage of the
// pipelined MIPS core.
//
// Each post-decode stage has one shadow slot (slot 0 = E). A slot holds a
// pending GPR write: valid bit, destination register, and tnew. tnew is the
// number of cycles left until the result can be forwarded. The block compares
// each D-stage source operand against the slots. From that it decides whether
// D must freeze, and which stage (if any) the operand is forwarded from. It
// also tracks how long the mult/div unit stays busy.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low; clears all state
//   issue_*      instruction leaving D for E (valid, wen, dst, tnew, md, div)
//   src_addr/src_tuse/src_en  per-operand source register, use time, enable
//   uses_md      D instruction touches HI/LO or the mult/div unit
//   stall        freeze F/D and inject a bubble into E
//   issue_ack    issue_valid & ~stall
//   fwd_sel      per operand, 3 bits: 0 = register file, k = slot k-1
//   md_busy      mult/div unit busy
module hazard_scoreboard #(
  parameter int NSTAGE   = 3,
  parameter int NSRC     = 2,
  parameter int AW       = 5,
  parameter int TW       = 2,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               issue_valid,
  input  logic               issue_wen,
  input  logic [AW-1:0]      issue_dst,
  input  logic [TW-1:0]      issue_tnew,
  input  logic               issue_md,
  input  logic               issue_div,
  input  logic [NSRC*AW-1:0] src_addr,
  input  logic [NSRC*TW-1:0] src_tuse,
  input  logic [NSRC-1:0]    src_en,
  input  logic               uses_md,
  output logic               stall,
  output logic               issue_ack,
  output logic [NSRC*3-1:0]  fwd_sel,
  output logic               md_busy
);

  localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int CW     = $clog2(MD_MAX + 1);

  logic [NSTAGE-1:0] vld_q, vld_d;
  logic [AW-1:0]     dst_q  [NSTAGE];
  logic [AW-1:0]     dst_d  [NSTAGE];
  logic [TW-1:0]     tnew_q [NSTAGE];
  logic [TW-1:0]     tnew_d [NSTAGE];
  logic              md_e_q, md_e_d;
  logic [CW-1:0]     md_cnt_q, md_cnt_d;
  logic [NSRC-1:0]   op_stall;
  logic              md_stall;

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  assign md_busy   = (md_cnt_q != '0);
  // md_e_q covers the cycle where a mult/div has just entered E.
  assign md_stall  = uses_md & (md_busy | md_e_q);
  assign stall     = (|op_stall) | md_stall;
  assign issue_ack = issue_valid & ~stall;

  // Operand resolution: only the youngest (lowest-index) match counts.
  always_comb begin
    logic          found;
    logic [AW-1:0] a;
    op_stall = '0;
    fwd_sel  = '0;
    for (int i = 0; i < NSRC; i++) begin
      found = 1'b0;
      a     = src_addr[i*AW +: AW];
      for (int k = 0; k < NSTAGE; k++) begin
        if (!found && src_en[i] && (a != '0) && vld_q[k] && (dst_q[k] == a)) begin
          found = 1'b1;
          if (tnew_q[k] > src_tuse[i*TW +: TW]) begin
            op_stall[i] = 1'b1;
          end else if (tnew_q[k] == '0) begin
            fwd_sel[i*3 +: 3] = 3'(k + 1);
          end
        end
      end
    end
  end

  // Next state of the shadow pipeline and the mult/div counter.
  always_comb begin
    vld_d[0]  = issue_ack & issue_wen & (issue_dst != '0);
    dst_d[0]  = issue_dst;
    tnew_d[0] = issue_tnew;
    for (int k = 1; k < NSTAGE; k++) begin
      vld_d[k]  = vld_q[k-1];
      dst_d[k]  = dst_q[k-1];
      tnew_d[k] = sat_dec(tnew_q[k-1]);
    end
    md_e_d   = issue_ack & issue_md;
    md_cnt_d = md_cnt_q;
    if (issue_ack && issue_md) begin
      md_cnt_d = issue_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  // Stage boundary: D -> E and onward through the tracked stages.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q    <= '0;
      md_e_q   <= 1'b0;
      md_cnt_q <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        dst_q[k]  <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      md_e_q   <= md_e_d;
      md_cnt_q <= md_cnt_d;
      for (int k = 0; k < NSTAGE; k++) begin
        dst_q[k]  <= dst_d[k];
        tnew_q[k] <= tnew_d[k];
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with a queue of expected outputs.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_wen, issue_md, issue_div, uses_md;
  logic [4:0]  issue_dst;
  logic [1:0]  issue_tnew;
  logic [9:0]  src_addr;
  logic [3:0]  src_tuse;
  logic [1:0]  src_en;
  logic        stall, issue_ack, md_busy;
  logic [5:0]  fwd_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       st;
    logic       ack;
    logic [5:0] fwd;
    logic       busy;
  } exp_t;
  exp_t exp_q[$];

  hazard_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_dst(issue_dst),
    .issue_tnew(issue_tnew), .issue_md(issue_md), .issue_div(issue_div),
    .src_addr(src_addr), .src_tuse(src_tuse), .src_en(src_en),
    .uses_md(uses_md), .stall(stall), .issue_ack(issue_ack),
    .fwd_sel(fwd_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic st, input logic ack,
                            input logic [5:0] fwd, input logic busy);
    exp_t e;
    e.tag = tag; e.st = st; e.ack = ack; e.fwd = fwd; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL queue observed=0 expected=1");
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp({e.tag, ".stall"}, int'(stall), int'(e.st));
      cmp({e.tag, ".ack"}, int'(issue_ack), int'(e.ack));
      cmp({e.tag, ".fwd"}, int'(fwd_sel), int'(e.fwd));
      cmp({e.tag, ".busy"}, int'(md_busy), int'(e.busy));
    end
  endtask

  // One cycle: record expectation, compare mid-cycle, then take the edge.
  task automatic step(input string tag, input logic st, input logic ack,
                      input logic [5:0] fwd, input logic busy);
    expect_out(tag, st, ack, fwd, busy);
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    issue_valid = 0; issue_wen = 0; issue_dst = 0; issue_tnew = 0;
    issue_md = 0; issue_div = 0; uses_md = 0;
    src_addr = 0; src_tuse = 0; src_en = 0;
  endtask

  task automatic iss(input logic wen, input logic [4:0] dst, input logic [1:0] tn,
                     input logic md, input logic dv);
    issue_valid = 1; issue_wen = wen; issue_dst = dst; issue_tnew = tn;
    issue_md = md; issue_div = dv;
  endtask

  task automatic rd(input int i, input logic [4:0] a, input logic [1:0] tu);
    src_en[i] = 1'b1;
    src_addr[i*5 +: 5] = a;
    src_tuse[i*2 +: 2] = tu;
  endtask

  task automatic flush();
    clr();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    clr();
    reset = 0;
    #2;
    expect_out("reset", 0, 0, 6'd0, 0);
    #1;
    sample();
    @(posedge clk);
    #1;
    reset = 1;

    // ALU $8 tnew=1, consumer tuse=0
    clr(); iss(1, 5'd8, 2'd1, 0, 0);
    step("alu_issue", 0, 1, 6'd0, 0);
    clr(); iss(0, 5'd0, 2'd0, 0, 0); rd(0, 5'd8, 2'd0);
    step("alu_stall", 1, 0, 6'd0, 0);
    step("alu_fwd", 0, 1, 6'd2, 0);
    flush();

    // lw $9 tnew=2, consumer tuse=1
    clr(); iss(1, 5'd9, 2'd2, 0, 0);
    step("lw_issue", 0, 1, 6'd0, 0);
    clr(); iss(0, 5'd0, 2'd0, 0, 0); rd(0, 5'd9, 2'd1);
    step("lw_stall", 1, 0, 6'd0, 0);
    step("lw_go", 0, 1, 6'd0, 0);
    issue_valid = 0;
    step("lw_fwd_w", 0, 0, 6'd3, 0);
    flush();

    // lw $9 tnew=2, consumer tuse=2 on operand 1
    clr(); iss(1, 5'd9, 2'd2, 0, 0);
    step("lw2_issue", 0, 1, 6'd0, 0);
    clr(); iss(0, 5'd0, 2'd0, 0, 0); rd(1, 5'd9, 2'd2);
    step("lw2_nostall", 0, 1, 6'd0, 0);
    flush();

    // jal $31 tnew=0, both operands read $31
    clr(); iss(1, 5'd31, 2'd0, 0, 0);
    step("jal_issue", 0, 1, 6'd0, 0);
    clr(); iss(0, 5'd0, 2'd0, 0, 0); rd(0, 5'd31, 2'd0); rd(1, 5'd31, 2'd0);
    step("jal_fwd_e", 0, 1, 6'b001001, 0);
    flush();

    // $10 written twice; youngest entry decides
    clr(); iss(1, 5'd10, 2'd2, 0, 0);
    step("dup_w1", 0, 1, 6'd0, 0);
    clr(); iss(1, 5'd10, 2'd1, 0, 0);
    step("dup_w2", 0, 1, 6'd0, 0);
    clr(); iss(0, 5'd0, 2'd0, 0, 0); rd(0, 5'd10, 2'd0);
    step("dup_stall", 1, 0, 6'd0, 0);
    step("dup_fwd_young", 0, 1, 6'd2, 0);
    flush();

    // $11 older stalls, younger forwardable: youngest must win
    clr(); iss(1, 5'd11, 2'd2, 0, 0);
    step("young_w1", 0, 1, 6'd0, 0);
    clr(); iss(1, 5'd11, 2'd0, 0, 0);
    step("young_w2", 0, 1, 6'd0, 0);
    clr(); rd(0, 5'd11, 2'd0);
    step("young_fwd", 0, 0, 6'd1, 0);
    flush();

    // div then mfhi: 10 busy cycles
    clr(); iss(0, 5'd0, 2'd0, 1, 1); uses_md = 1;
    step("div_issue", 0, 1, 6'd0, 0);
    clr(); iss(1, 5'd12, 2'd1, 0, 0); uses_md = 1;
    for (int n = 0; n < 10; n++) step("div_busy", 1, 0, 6'd0, 1);
    step("div_done", 0, 1, 6'd0, 0);
    flush();

    // mult then mfhi: 5 busy cycles
    clr(); iss(0, 5'd0, 2'd0, 1, 0); uses_md = 1;
    step("mult_issue", 0, 1, 6'd0, 0);
    clr(); iss(1, 5'd12, 2'd1, 0, 0); uses_md = 1;
    for (int n = 0; n < 5; n++) step("mult_busy", 1, 0, 6'd0, 1);
    step("mult_done", 0, 1, 6'd0, 0);
    flush();

    // writes to $0 and disabled operands never stall
    clr(); iss(1, 5'd0, 2'd2, 0, 0);
    step("zero_issue", 0, 1, 6'd0, 0);
    clr(); iss(1, 5'd13, 2'd2, 0, 0); rd(0, 5'd0, 2'd0);
    step("zero_read", 0, 1, 6'd0, 0);
    clr(); src_addr[4:0] = 5'd13; src_en = 2'b00;
    step("src_disabled", 0, 0, 6'd0, 0);
    flush();

    // reset mid-operation clears pending writes and md counter
    clr(); iss(0, 5'd0, 2'd0, 1, 1); uses_md = 1;
    step("rst_div", 0, 1, 6'd0, 0);
    clr(); iss(1, 5'd14, 2'd2, 0, 0);
    step("rst_w14", 0, 1, 6'd0, 1);
    clr(); rd(0, 5'd14, 2'd0);
    step("rst_pre", 1, 0, 6'd0, 1);
    reset = 0;
    expect_out("rst_async", 0, 0, 6'd0, 0);
    #2;
    sample();
    @(posedge clk);
    #1;
    reset = 1;
    step("rst_post", 0, 0, 6'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
